// File: rtl/bus_width_bridge.sv
// bus_width_bridge
//   Down-sizing bridge: wide (DBUS-bit) words with an ABUS-bit base address
//   are buffered in a DEPTH-entry FIFO and then serialised into
//   RATIO = DBUS/SWIDTH narrow beats with an auto-incrementing address.
//
// Ports
//   clk, rst_n            single rising-edge clock, async active-low reset
//   in_valid/in_ready     wide-side handshake
//   in_addr, in_data      wide word base address and data
//   out_valid/out_ready   narrow-side handshake
//   out_addr, out_data    beat address (base + beat) and beat data
//   out_last              final beat of the current wide word
//   busy                  FIFO non-empty or serialiser active
//   fifo_count            current FIFO occupancy
module bus_width_bridge #(
  parameter int DBUS      = 32,
  parameter int ABUS      = 8,
  parameter int SWIDTH    = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ABUS-1:0]          in_addr,
  input  logic [DBUS-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ABUS-1:0]          out_addr,
  output logic [SWIDTH-1:0]        out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int RATIO = DBUS / SWIDTH;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  // FIFO storage
  logic [ABUS-1:0] mem_addr_q [DEPTH];
  logic [DBUS-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Serialiser
  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q,  beat_d;
  logic [ABUS-1:0] base_q,  base_d;
  logic [DBUS-1:0] sreg_q,  sreg_d;

  logic push, pop, hs, last_beat;

  assign in_ready   = (count_q < FULL_CNT);
  assign push       = in_valid && in_ready;
  assign hs         = out_valid && out_ready;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign fifo_count = count_q;
  assign busy       = (count_q != '0) || (state_q == SEND);

  // FIFO storage carries no reset: contents are only ever read after a push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= in_addr;
      mem_data_q[wr_ptr_q] <= in_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      beat_q   <= '0;
      base_q   <= '0;
      sreg_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      sreg_q   <= sreg_d;
    end
  end

  // Next-state logic. The serialiser keeps the current slice at the output
  // end of a shift register, so each accepted beat just shifts by SWIDTH.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    sreg_d  = sreg_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (!last_beat) begin
            beat_d = beat_q + BW'(1);
            if (MSB_FIRST != 0) sreg_d = sreg_q << SWIDTH;
            else                sreg_d = sreg_q >> SWIDTH;
          end else if (count_q != '0) begin
            // Back-to-back load keeps the output stream free of bubbles.
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      beat_d = '0;
      base_d = mem_addr_q[rd_ptr_q];
      sreg_d = mem_data_q[rd_ptr_q];
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Output logic
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_last  = last_beat;
      out_addr  = base_q + ABUS'(beat_q);
      if (MSB_FIRST != 0) out_data = sreg_q[DBUS-1 -: SWIDTH];
      else                out_data = sreg_q[SWIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_bus_width_bridge.sv
module tb_bus_width_bridge;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last, busy;
  logic [7:0]  out_addr, out_data;
  logic [2:0]  fifo_count;

  logic        m_in_valid, m_in_ready;
  logic [7:0]  m_in_addr;
  logic [31:0] m_in_data;
  logic        m_out_valid, m_out_ready, m_out_last, m_busy;
  logic [7:0]  m_out_addr, m_out_data;
  logic [2:0]  m_fifo_count;

  int unsigned n_checks;
  int unsigned n_fail;

  bus_width_bridge #(.DBUS(32), .ABUS(8), .SWIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .fifo_count(fifo_count)
  );

  bus_width_bridge #(.DBUS(32), .ABUS(8), .SWIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_addr(m_in_addr), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_addr(m_out_addr),
    .out_data(m_out_data), .out_last(m_out_last), .busy(m_busy), .fifo_count(m_fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Word i of the streaming tests: byte j = 16*i + j, base address 0x40 + 4*i.
  function automatic logic [31:0] wdata(input int i);
    return {8'(16*i+3), 8'(16*i+2), 8'(16*i+1), 8'(16*i)};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_data = '0; out_ready = 1'b0;
    m_in_valid = 1'b0; m_in_addr = '0; m_in_data = '0; m_out_ready = 1'b0;
    tick; tick;
    n_checks++;
    if ({out_valid, out_last, out_addr, out_data, busy, fifo_count} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b a=%h d=%h busy=%b cnt=%0d, want all zero",
               out_valid, out_last, out_addr, out_data, busy, fifo_count);
    end
    rst_n = 1'b1;
    tick;
    n_checks++;
    if ({in_ready, out_valid, busy, fifo_count} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b v=%b busy=%b cnt=%0d, want 1 0 0 0",
               in_ready, out_valid, busy, fifo_count);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [4];
    exp_d = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    out_ready = 1'b1;
    in_valid = 1'b1; in_addr = 8'h10; in_data = 32'hA1B2C3D4;
    tick;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, busy, fifo_count} !== 5'b01001) begin
      n_fail++;
      $display("FAIL basic_latency: got v=%b busy=%b cnt=%0d, want v=0 busy=1 cnt=1",
               out_valid, busy, fifo_count);
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out_valid, out_last, out_addr, out_data} !== {1'b1, (i == 3), 8'(8'h10 + i), exp_d[i]}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got v=%b l=%b a=%h d=%h, want v=1 l=%b a=%h d=%h",
                 i, out_valid, out_last, out_addr, out_data, (i == 3), 8'(8'h10 + i), exp_d[i]);
      end
      tick;
    end
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_done: got v=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_d [4];
    logic [7:0] exp_a [4];
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    out_ready = 1'b1;
    in_valid = 1'b1; in_addr = 8'hFE; in_data = 32'h04030201;
    tick;
    in_valid = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({out_valid, out_last, out_addr, out_data} !== {1'b1, (i == 3), exp_a[i], exp_d[i]}) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got v=%b l=%b a=%h d=%h, want v=1 l=%b a=%h d=%h",
                 i, out_valid, out_last, out_addr, out_data, (i == 3), exp_a[i], exp_d[i]);
      end
      tick;
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] exp_d [4];
    exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    m_out_ready = 1'b1;
    m_in_valid = 1'b1; m_in_addr = 8'h20; m_in_data = 32'hA1B2C3D4;
    tick;
    m_in_valid = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({m_out_valid, m_out_last, m_out_addr, m_out_data} !== {1'b1, (i == 3), 8'(8'h20 + i), exp_d[i]}) begin
        n_fail++;
        $display("FAIL msb_beat%0d: got v=%b l=%b a=%h d=%h, want v=1 l=%b a=%h d=%h",
                 i, m_out_valid, m_out_last, m_out_addr, m_out_data, (i == 3), 8'(8'h20 + i), exp_d[i]);
      end
      tick;
    end
    n_checks++;
    if ({m_out_valid, m_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL msb_done: got v=%b busy=%b, want 0 0", m_out_valid, m_busy);
    end
  endtask

  task automatic test_backpressure_full;
    int   acc;
    logic taken;
    acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_addr = 8'(64 + 4*acc);
      in_data = wdata(acc);
      taken = in_ready;
      tick;
      if (taken) acc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (acc !== 5) begin
      n_fail++;
      $display("FAIL full_accepted: got %0d words, want 5", acc);
    end
    n_checks++;
    if ({in_ready, fifo_count} !== 4'b0100) begin
      n_fail++;
      $display("FAIL full_status: got in_ready=%b cnt=%0d, want 0 4", in_ready, fifo_count);
    end
    n_checks++;
    if ({out_valid, out_last, out_addr, out_data} !== {1'b1, 1'b0, 8'h40, 8'h00}) begin
      n_fail++;
      $display("FAIL full_held_beat: got v=%b l=%b a=%h d=%h, want v=1 l=0 a=40 d=00",
               out_valid, out_last, out_addr, out_data);
    end

    // One-cycle out_ready pulse: consumes a non-last beat, occupancy unchanged.
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, fifo_count, out_addr, out_data} !== {1'b0, 3'd4, 8'h41, 8'h01}) begin
      n_fail++;
      $display("FAIL pulse_full: got in_ready=%b cnt=%0d a=%h d=%h, want 0 4 41 01",
               in_ready, fifo_count, out_addr, out_data);
    end
    tick;
    n_checks++;
    if ({out_valid, out_addr, out_data} !== {1'b1, 8'h41, 8'h01}) begin
      n_fail++;
      $display("FAIL pulse_hold: got v=%b a=%h d=%h, want v=1 a=41 d=01",
               out_valid, out_addr, out_data);
    end

    // Drain the remaining beats with out_ready held high.
    out_ready = 1'b1;
    for (int g = 1; g < 20; g++) begin
      n_checks++;
      if ({out_valid, out_last, out_addr, out_data} !==
          {1'b1, (g % 4 == 3), 8'(64 + g), 8'(16*(g/4) + g%4)}) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got v=%b l=%b a=%h d=%h, want v=1 l=%b a=%h d=%h",
                 g, out_valid, out_last, out_addr, out_data,
                 (g % 4 == 3), 8'(64 + g), 8'(16*(g/4) + g%4));
      end
      if (g == 4) begin
        n_checks++;
        if ({in_ready, fifo_count} !== 4'b1011) begin
          n_fail++;
          $display("FAIL pop_at_full: got in_ready=%b cnt=%0d, want 1 3", in_ready, fifo_count);
        end
      end
      tick;
    end
    n_checks++;
    if ({out_valid, busy, fifo_count} !== 5'b00000) begin
      n_fail++;
      $display("FAIL stream_done: got v=%b busy=%b cnt=%0d, want 0 0 0",
               out_valid, busy, fifo_count);
    end
  endtask

  task automatic test_reset_mid_burst;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 8; i < 11; i++) begin
      in_addr = 8'(64 + 4*i);
      in_data = wdata(i);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick; tick;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, fifo_count, out_addr, out_data} !== {1'b1, 3'd2, 8'h62, 8'h82}) begin
      n_fail++;
      $display("FAIL midburst_setup: got v=%b cnt=%0d a=%h d=%h, want 1 2 62 82",
               out_valid, fifo_count, out_addr, out_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, fifo_count, busy} !== 5'b00000) begin
      n_fail++;
      $display("FAIL midburst_reset: got v=%b cnt=%0d busy=%b, want 0 0 0",
               out_valid, fifo_count, busy);
    end
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_checks++;
      if ({out_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL post_reset_idle%0d: got v=%b busy=%b, want 0 0", i, out_valid, busy);
      end
    end
    in_valid = 1'b1; in_addr = 8'h80; in_data = 32'h55667788;
    tick;
    in_valid = 1'b0;
    tick;
    n_checks++;
    if ({out_valid, out_last, out_addr, out_data} !== {1'b1, 1'b0, 8'h80, 8'h88}) begin
      n_fail++;
      $display("FAIL post_reset_word: got v=%b l=%b a=%h d=%h, want v=1 l=0 a=80 d=88",
               out_valid, out_last, out_addr, out_data);
    end
    repeat (4) tick;
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_drain: got v=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_basic;
    test_wrap;
    test_msb_first;
    test_backpressure_full;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_width_bridge.md
Name: bus_width_bridge

Overview:
- Parameterised down-sizing bridge from a wide address/data bus (DBUS-bit data, ABUS-bit address) to a narrow bus (SWIDTH-bit data).
- Incoming wide words are buffered in a DEPTH-entry FIFO, then serialised into RATIO = DBUS/SWIDTH narrow beats with auto-incrementing address.
- Beat order is selectable, and both sides use valid/ready handshakes.
- Sits between a fast-bus master and slow-bus peripherals in the top-level interconnect.

Parameters:
- DBUS, 32, wide data width; must be an integer multiple of SWIDTH.
- ABUS, 8, address width on both sides.
- SWIDTH, 8, narrow data width.
- DEPTH, 4, input FIFO entries; power of two, >= 2.
- MSB_FIRST, 0, 0 = least-significant slice first, 1 = most-significant slice first.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  wide word offered.
- in_ready  output  1  bridge can accept a wide word.
- in_addr  input  ABUS  base address of wide word.
- in_data  input  DBUS  wide data.
- out_valid  output  1  narrow beat valid.
- out_ready  input  1  downstream accepts beat.
- out_addr  output  ABUS  beat address.
- out_data  output  SWIDTH  beat data.
- out_last  output  1  final beat of current wide word.
- busy  output  1  FIFO non-empty or serialiser active.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count are 0.
  - State is IDLE; beat counter is 0; shift register is 0.
  - Outputs: out_valid=0, out_last=0, out_addr=0, out_data=0, busy=0, fifo_count=0.
  - in_ready=1 once reset is released.
  - Reset mid-burst discards all buffered and in-flight data; no partial beats appear after release.
- FIFO:
  - Push when in_valid && in_ready. in_ready = (count < DEPTH), driven combinationally from registered count.
  - Pop only when the serialiser loads.
  - Simultaneous push and pop leaves count unchanged. Pop while full frees a slot the next cycle, not the same cycle.
  - Pointers wrap modulo DEPTH.
- Serialiser FSM, states IDLE and SEND:
  - IDLE: when count > 0, pop head on the clock edge, load base address and data, set beat=0, go to SEND.
  - SEND:
    - out_valid=1.
    - out_data = slice[beat] when MSB_FIRST=0, slice[RATIO-1-beat] when MSB_FIRST=1. slice[i] = data[i*SWIDTH +: SWIDTH].
    - out_addr = base + beat, truncated to ABUS bits (wraps modulo 2^ABUS).
    - out_last = (beat == RATIO-1).
  - Handshake on out_valid && out_ready:
    - If not last, beat increments.
    - If last and count > 0, pop and load the next word in the same edge, staying in SEND (no bubble).
    - If last and count == 0, go to IDLE with out_valid=0.
  - While out_valid=1 and out_ready=0: out_data, out_addr and out_last hold stable; out_valid never drops without a handshake.
- Latency: a word pushed at edge k into an empty bridge produces its first beat with out_valid=1 after edge k+1.
- Throughput: one narrow beat per cycle with out_ready held high. Sustained input rate is one wide word per RATIO cycles.
- RATIO=1 (DBUS==SWIDTH): every beat has out_last=1, and the block behaves as a FIFO.
- Capacity: with out_ready=0, DEPTH+1 words are accepted in total (DEPTH in FIFO plus one in the shift register).
- busy = (count != 0) || (state == SEND).

Test Plan:
- Basic word (defaults): push addr 0x10, data 0xA1B2C3D4 with out_ready=1 -> beats D4@0x10, C3@0x11, B2@0x12, A1@0x13. out_last only on the 4th beat; first out_valid 2 cycles after push; busy drops the cycle after the last beat.
- Address wrap: push addr 0xFE, data 0x04030201 -> beats 01@0xFE, 02@0xFF, 03@0x00, 04@0x01.
- MSB_FIRST=1: push addr 0x20, data 0xA1B2C3D4 -> beats A1@0x20, B2@0x21, C3@0x22, D4@0x23.
- Back-pressure and full:
  - Hold out_ready=0 and offer 8 consecutive words -> 5 accepted; in_ready=0 with fifo_count=4; first beat held stable.
  - Then release out_ready -> 20 beats back-to-back with no bubbles and words in push order.
- Simultaneous push/pop at full:
  - Pulse out_ready for one cycle -> fifo_count stays 4 and in_ready stays 0.
  - On completing a last beat while full -> count becomes 3 and in_ready=1 the following cycle.
- Reset mid-burst: assert rst_n=0 after beat 2 of a word with 2 words queued -> out_valid=0 and fifo_count=0 immediately. After release, no beats appear until a new push.
